// File: rtl/alu_if.sv
// alu_if -- operand/result bundle of the FlyCPU ALU.
//   A, B  : 64-bit operands (B[5:0] is the shift/rotate amount)
//   MODE  : 4-bit operation select
//   S     : primary 64-bit result (registered in the ALU)
//   S2    : secondary 64-bit result (carry/borrow word or product high half)
//   PSW   : 16-bit status word {12'b0, OF, SF, ZF, CF}
// The master drives operands and reads results; the slave (the ALU) does the reverse.
interface alu_if;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  MODE;
  logic [63:0] S;
  logic [63:0] S2;
  logic [15:0] PSW;

  modport master (output A, B, MODE, input S, S2, PSW);
  modport slave  (input A, B, MODE, output S, S2, PSW);
endinterface

// File: rtl/alu.sv
// alu -- 64-bit registered arithmetic/logic unit of the FlyCPU datapath.
//   CLK : rising-edge clock
//   RST : asynchronous active-high reset; clears S, S2 and PSW
//   bus : alu_if slave port (A, B, MODE in; S, S2, PSW out)
// All results are computed combinationally from A, B, MODE and the registered
// carry flag, and load into the output registers on every rising CLK edge.
module alu (
  input  logic CLK,
  input  logic RST,
  alu_if.slave bus
);

  typedef enum logic [3:0] {
    MODE_ADD  = 4'd0,  MODE_SUB = 4'd1,  MODE_MUL = 4'd2,  MODE_IMUL = 4'd3,
    MODE_AND  = 4'd4,  MODE_OR  = 4'd5,  MODE_XOR = 4'd6,  MODE_NOT  = 4'd7,
    MODE_SHL  = 4'd8,  MODE_SHR = 4'd9,  MODE_SAR = 4'd10, MODE_ROL  = 4'd11,
    MODE_ROR  = 4'd12, MODE_CMP = 4'd13, MODE_ADC = 4'd14, MODE_SBB  = 4'd15
  } mode_e;

  logic [63:0] s_q, s2_q;
  logic [15:0] psw_q;

  logic [63:0] a, b;
  mode_e       mode;
  logic [5:0]  amt;
  logic        cin;
  logic [64:0] add_w, sub_w;
  logic [127:0] prod_u, prod_s;
  logic [64:0] shl_w, shr_w, sar_w;
  logic [63:0] rol_r, ror_r;
  logic        add_of, sub_of;

  logic [63:0] s_n, s2_n;
  logic        cf_n, of_n, zf_n, sf_n;

  assign a    = bus.A;
  assign b    = bus.B;
  assign mode = mode_e'(bus.MODE);
  assign amt  = b[5:0];

  // Only ADC/SBB consume the previous cycle's carry.
  assign cin = ((mode == MODE_ADC) || (mode == MODE_SBB)) ? psw_q[0] : 1'b0;

  // 65-bit sums: bit 64 is the carry out (add) or the borrow (subtract wraps negative).
  assign add_w = {1'b0, a} + {1'b0, b} + {64'd0, cin};
  assign sub_w = {1'b0, a} - {1'b0, b} - {64'd0, cin};

  assign add_of = (a[63] == b[63]) && (add_w[63] != a[63]);
  assign sub_of = (a[63] != b[63]) && (sub_w[63] != a[63]);

  // Low 128 bits of the product of sign-extended operands is the signed product.
  assign prod_u = {64'd0, a} * {64'd0, b};
  assign prod_s = {{64{a[63]}}, a} * {{64{b[63]}}, b};

  // One extra bit on the side the data leaves catches the last bit shifted out;
  // with amount 0 that bit stays 0, which gives CF=0 for free.
  assign shl_w = {1'b0, a} << amt;
  assign shr_w = {a, 1'b0} >> amt;
  assign sar_w = 65'($signed({a, 1'b0}) >>> amt);

  // Right-hand shift by 64 (amount 0) yields 0, so the rotate degenerates to A.
  assign rol_r = (a << amt) | (a >> (7'd64 - {1'b0, amt}));
  assign ror_r = (a >> amt) | (a << (7'd64 - {1'b0, amt}));

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    s_n  = '0;
    s2_n = '0;
    cf_n = 1'b0;
    of_n = 1'b0;
    unique case (mode)
      MODE_ADD, MODE_ADC: begin
        s_n  = add_w[63:0];
        s2_n = {63'd0, add_w[64]};
        cf_n = add_w[64];
        of_n = add_of;
      end
      MODE_SUB, MODE_SBB: begin
        s_n  = sub_w[63:0];
        s2_n = {63'd0, sub_w[64]};
        cf_n = sub_w[64];
        of_n = sub_of;
      end
      MODE_CMP: begin
        s_n  = a;
        cf_n = sub_w[64];
        of_n = sub_of;
      end
      MODE_MUL: begin
        {s2_n, s_n} = prod_u;
        cf_n = (prod_u[127:64] != 64'd0);
        of_n = cf_n;
      end
      MODE_IMUL: begin
        {s2_n, s_n} = prod_s;
        cf_n = (prod_s[127:64] != {64{prod_s[63]}});
        of_n = cf_n;
      end
      MODE_AND: s_n = a & b;
      MODE_OR:  s_n = a | b;
      MODE_XOR: s_n = a ^ b;
      MODE_NOT: s_n = ~a;
      MODE_SHL: {cf_n, s_n} = shl_w;
      MODE_SHR: {s_n, cf_n} = shr_w;
      MODE_SAR: {s_n, cf_n} = sar_w;
      MODE_ROL: begin
        s_n  = rol_r;
        cf_n = (amt != 6'd0) && rol_r[0];
      end
      MODE_ROR: begin
        s_n  = ror_r;
        cf_n = (amt != 6'd0) && ror_r[63];
      end
      default: ;
    endcase
    // CMP reports flags of A-B while passing A through.
    zf_n = (mode == MODE_CMP) ? (sub_w[63:0] == 64'd0) : (s_n == 64'd0);
    sf_n = (mode == MODE_CMP) ? sub_w[63] : s_n[63];
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, including the CF fed back into ADC/SBB.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_q   <= '0;
      s2_q  <= '0;
      psw_q <= '0;
    end else begin
      s_q   <= s_n;
      s2_q  <= s2_n;
      psw_q <= {12'd0, of_n, sf_n, zf_n, cf_n};
    end
  end

  assign bus.S   = s_q;
  assign bus.S2  = s2_q;
  assign bus.PSW = psw_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu -- directed self-checking bench for the FlyCPU ALU.
module tb_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] ADD = 4'd0,  SUB = 4'd1,  MUL = 4'd2,  IMUL = 4'd3,
                         AND_ = 4'd4, OR_ = 4'd5,  XOR_ = 4'd6, NOT_ = 4'd7,
                         SHL = 4'd8,  SHR = 4'd9,  SAR = 4'd10, ROL = 4'd11,
                         ROR = 4'd12, CMP = 4'd13, ADC = 4'd14, SBB = 4'd15;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  alu_if bus ();

  alu dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one operation, clock it in, and sample 1 time unit after the edge.
  task automatic op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m);
    bus.A = a;
    bus.B = b;
    bus.MODE = m;
    @(posedge clk);
    #1;
  endtask

  task automatic expect3(input string tag, input logic [63:0] s,
                         input logic [63:0] s2, input logic [15:0] psw);
    check({tag, ".S"},   bus.S,   s);
    check({tag, ".S2"},  bus.S2,  s2);
    check({tag, ".PSW"}, {48'd0, bus.PSW}, {48'd0, psw});
  endtask

  initial begin
    bus.A = '0; bus.B = '0; bus.MODE = ADD;
    #12;
    expect3("reset", 64'd0, 64'd0, 16'h0000);
    rst = 1'b0;
    #1;

    op(64'h20, 64'h30, ADD);        expect3("add",      64'h50, 64'd0, 16'h0000);
    op(bus.S, 64'h40, SUB);         expect3("sub_fb",   64'h10, 64'd0, 16'h0000);
    op(64'h10, 64'h40, SUB);        expect3("sub_neg",  64'hFFFF_FFFF_FFFF_FFD0, 64'd1, 16'h0005);
    op(ONES, 64'd1, ADD);           expect3("add_cy",   64'd0, 64'd1, 16'h0003);
    op(64'd0, 64'd0, ADC);          expect3("adc_cin",  64'd1, 64'd0, 16'h0000);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ADD);
                                    expect3("add_ovf",  64'h8000_0000_0000_0000, 64'd0, 16'h000C);
    op(64'h8000_0000_0000_0000, 64'd1, SUB);
                                    expect3("sub_ovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 16'h0008);
    op(64'h8000_0000_0000_0000, 64'd4, MUL);
                                    expect3("mul",      64'd0, 64'd2, 16'h000B);
    op(-64'sd3, 64'd5, IMUL);       expect3("imul",     -64'sd15, ONES, 16'h0004);
    op(64'h4000_0000_0000_0000, 64'd4, IMUL);
                                    expect3("imul_ovf", 64'd0, 64'd1, 16'h000B);

    op(64'h8000_0000_0000_0001, 64'd1, SHL); expect3("shl", 64'd2, 64'd0, 16'h0001);
    op(64'h8000_0000_0000_0001, 64'd1, SHR); expect3("shr", 64'h4000_0000_0000_0000, 64'd0, 16'h0001);
    op(64'h8000_0000_0000_0001, 64'd1, SAR); expect3("sar", 64'hC000_0000_0000_0000, 64'd0, 16'h0005);
    op(64'h8000_0000_0000_0001, 64'd1, ROL); expect3("rol", 64'd3, 64'd0, 16'h0001);
    op(64'h8000_0000_0000_0001, 64'd1, ROR); expect3("ror", 64'hC000_0000_0000_0000, 64'd0, 16'h0005);
    op(64'h8000_0000_0000_0001, 64'h40, SHL);
                                    expect3("shl_zero", 64'h8000_0000_0000_0001, 64'd0, 16'h0004);

    op(64'd5, 64'd5, CMP);          expect3("cmp_eq",   64'd5, 64'd0, 16'h0002);
    op(64'd1, 64'd2, CMP);          expect3("cmp_lt",   64'd1, 64'd0, 16'h0005);
    op(64'hF0, 64'h0F, AND_);       expect3("and",      64'd0, 64'd0, 16'h0002);
    op(64'hF0, 64'h0F, OR_);        expect3("or",       64'hFF, 64'd0, 16'h0000);
    op(64'hFF, 64'hFF, XOR_);       expect3("xor",      64'd0, 64'd0, 16'h0002);
    op(64'd0, 64'd0, NOT_);         expect3("not",      ONES, 64'd0, 16'h0004);

    op(64'd0, 64'd1, SUB);          expect3("sub_bw",   ONES, 64'd1, 16'h0005);
    op(64'd10, 64'd3, SBB);         expect3("sbb",      64'd6, 64'd0, 16'h0000);

    // Mid-cycle reset after a borrow: outputs clear at once, edges are ignored,
    // and the stale carry must not reach the following ADC.
    op(64'd0, 64'd1, SUB);          expect3("pre_rst",  ONES, 64'd1, 16'h0005);
    #2 rst = 1'b1;
    #1;                             expect3("rst_async", 64'd0, 64'd0, 16'h0000);
    op(64'd1, 64'd1, ADD);          expect3("rst_hold",  64'd0, 64'd0, 16'h0000);
    #3 rst = 1'b0;
    op(64'd0, 64'd0, ADC);          expect3("adc_post_rst", 64'd0, 64'd0, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
